rate_counter: RTL

- Parametrised successor to the fixed 500 Hz / 50 MHz rate-divider-plus-display-counter pair.
- One block holds two parts: a speed-selectable enable generator sized from the input clock frequency, and a modulo counter driven by that enable.
- The counter adds up/down direction, a programmable maximum, synchronous load, pause and a wrap pulse.
- It sits between the board clock and a hex_decoder, or any other consumer of a slow count.

---
 rtl/rate_counter.sv | 91 +++++++++
 1 files changed

// File: rtl/rate_counter.sv
// Rate-selectable enable generator driving an up/down modulo counter with load,
// pause and a registered wrap pulse. Tick period is R(Speed)+1 ClockIn cycles.
module rate_counter #(
   parameter int CLK_HZ  = 500,
   parameter int COUNT_W = 4,
   parameter int DIV_W   = 11
) (
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic [1:0]         Speed,
   input  logic               Pause,
   input  logic               Up,
   input  logic               Load,
   input  logic [COUNT_W-1:0] LoadValue,
   input  logic [COUNT_W-1:0] MaxValue,
   output logic               Tick,
   output logic [COUNT_W-1:0] CounterValue,
   output logic               Wrap
);

   localparam logic [DIV_W-1:0] RELOAD_1HZ  = DIV_W'(CLK_HZ - 1);
   localparam logic [DIV_W-1:0] RELOAD_HALF = DIV_W'(2 * CLK_HZ - 1);
   localparam logic [DIV_W-1:0] RELOAD_QTR  = DIV_W'(4 * CLK_HZ - 1);

   logic [DIV_W-1:0] divider;
   logic [DIV_W-1:0] reload;
   logic [1:0]       speed_q;

   always_comb begin
      reload = '0;
      case (Speed)
         2'b00:   reload = '0;
         2'b01:   reload = RELOAD_1HZ;
         2'b10:   reload = RELOAD_HALF;
         default: reload = RELOAD_QTR;
      endcase
   end

   // A speed change masks Tick for that cycle so the old period cannot leak a pulse.
   assign Tick = (divider == '0) & ~Pause & (Speed == speed_q);

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         divider <= '0;
         speed_q <= 2'b00;
      end else if (Speed != speed_q) begin
         divider <= reload;
         speed_q <= Speed;
      end else if (Load) begin
         divider <= reload;
      end else if (!Pause) begin
         if (divider == '0)
            divider <= reload;
         else
            divider <= divider - DIV_W'(1);
      end
   end

   // Load outranks a coincident Tick; out-of-range counts snap back on the next Tick.
   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         CounterValue <= '0;
         Wrap         <= 1'b0;
      end else if (Load) begin
         CounterValue <= LoadValue;
         Wrap         <= 1'b0;
      end else if (Tick && Up) begin
         if (CounterValue >= MaxValue) begin
            CounterValue <= '0;
            Wrap         <= 1'b1;
         end else begin
            CounterValue <= CounterValue + COUNT_W'(1);
            Wrap         <= 1'b0;
         end
      end else if (Tick) begin
         if (CounterValue == '0) begin
            CounterValue <= MaxValue;
            Wrap         <= 1'b1;
         end else if (CounterValue > MaxValue) begin
            CounterValue <= MaxValue;
            Wrap         <= 1'b0;
         end else begin
            CounterValue <= CounterValue - COUNT_W'(1);
            Wrap         <= 1'b0;
         end
      end else begin
         Wrap <= 1'b0;
      end
   end

endmodule
